// File: rtl/gaussian_job_scheduler.sv
// rtl/gaussian_job_scheduler.sv - job-level controller for the Gaussian filter wrapper
//
// Accepts {id, lines} jobs, resets the wrapper for two cycles, pulses start,
// watches the run (finish / abort / watchdog), and posts one completion record
// per job into a small FIFO. Zero-length jobs skip the wrapper entirely.

module gaussian_job_scheduler #(
   parameter int LINE_W   = 18,
   parameter int CYCLE_W  = 32,
   parameter int TIMEOUT  = 2**24,
   parameter int CQ_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [7:0]         job_id,
   input  logic [LINE_W-1:0]  job_lines,
   input  logic               abort,
   output logic               wrap_reset,
   output logic               wrap_start,
   input  logic               wrap_finish,
   output logic [LINE_W-1:0]  cfg_lines,
   output logic               busy,
   output logic               cpl_valid,
   input  logic               cpl_ready,
   output logic [7:0]         cpl_id,
   output logic [CYCLE_W-1:0] cpl_cycles,
   output logic [1:0]         cpl_status
);

   localparam int PTR_W = (CQ_DEPTH > 1) ? $clog2(CQ_DEPTH) : 1;
   localparam int CNT_W = $clog2(CQ_DEPTH + 1);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ABORT   = 2'b10;
   localparam logic [1:0] ST_ZERO    = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_START,
      S_RUN,
      S_POST
   } state_t;

   state_t state_q, state_d;

   // second CLEAR cycle marker
   logic               clr2_q, clr2_d;
   logic [7:0]         id_q, id_d;
   logic [LINE_W-1:0]  lines_q, lines_d;
   logic [CYCLE_W-1:0] cyc_q, cyc_d;
   logic [1:0]         status_q, status_d;
   logic               wrap_reset_q, wrap_reset_d;
   logic               wrap_start_q, wrap_start_d;

   // completion queue storage and pointers
   logic [7:0]         cq_id     [CQ_DEPTH];
   logic [CYCLE_W-1:0] cq_cycles [CQ_DEPTH];
   logic [1:0]         cq_status [CQ_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic cq_full;
   logic cq_push;
   logic cq_pop;
   logic [CYCLE_W-1:0] cyc_inc;

   // saturating increment of the run-cycle counter
   assign cyc_inc = (cyc_q == {CYCLE_W{1'b1}}) ? cyc_q : cyc_q + 1'b1;

   // state and datapath registers; reset parks the wrapper in reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         clr2_q       <= 1'b0;
         id_q         <= '0;
         lines_q      <= '0;
         cyc_q        <= '0;
         status_q     <= '0;
         wrap_reset_q <= 1'b1;
         wrap_start_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         clr2_q       <= clr2_d;
         id_q         <= id_d;
         lines_q      <= lines_d;
         cyc_q        <= cyc_d;
         status_q     <= status_d;
         wrap_reset_q <= wrap_reset_d;
         wrap_start_q <= wrap_start_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // queue payload storage; only pointers need reset
   always_ff @(posedge clk) begin
      if (cq_push) begin
         cq_id[wr_ptr_q]     <= id_q;
         cq_cycles[wr_ptr_q] <= cyc_q;
         cq_status[wr_ptr_q] <= status_q;
      end
   end

   // next-state and job datapath
   always_comb begin
      state_d  = state_q;
      clr2_d   = clr2_q;
      id_d     = id_q;
      lines_d  = lines_q;
      cyc_d    = cyc_q;
      status_d = status_q;
      case (state_q)
         S_IDLE: begin
            if (job_valid) begin
               id_d    = job_id;
               lines_d = job_lines;
               if (job_lines != '0) begin
                  state_d = S_CLEAR;
                  clr2_d  = 1'b0;
               end else begin
                  state_d  = S_POST;
                  cyc_d    = '0;
                  status_d = ST_ZERO;
               end
            end
         end
         S_CLEAR: begin
            if (clr2_q) begin
               state_d = S_START;
               cyc_d   = {{(CYCLE_W-1){1'b0}}, 1'b1};
            end else begin
               clr2_d = 1'b1;
            end
         end
         S_START: begin
            state_d = S_RUN;
            cyc_d   = cyc_inc;
         end
         S_RUN: begin
            if (wrap_finish) begin
               state_d  = S_POST;
               status_d = ST_OK;
            end else if (abort) begin
               state_d  = S_POST;
               status_d = ST_ABORT;
            end else if (cyc_q == CYCLE_W'(TIMEOUT)) begin
               state_d  = S_POST;
               status_d = ST_TIMEOUT;
            end else begin
               cyc_d = cyc_inc;
            end
         end
         S_POST: begin
            if (cq_push) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // wrapper controls registered from the next state so they align with it
   always_comb begin
      wrap_reset_d = 1'b0;
      wrap_start_d = 1'b0;
      if (state_d == S_CLEAR) begin
         wrap_reset_d = 1'b1;
      end
      if (state_d == S_POST && (status_d == ST_TIMEOUT || status_d == ST_ABORT)) begin
         wrap_reset_d = 1'b1;
      end
      if (state_d == S_START) begin
         wrap_start_d = 1'b1;
      end
   end

   // completion queue push/pop bookkeeping; push may use a same-cycle pop slot
   always_comb begin
      cq_full  = (count_q == CNT_W'(CQ_DEPTH));
      cq_pop   = (count_q != '0) && cpl_ready;
      cq_push  = (state_q == S_POST) && (!cq_full || cq_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (cq_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(CQ_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (cq_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(CQ_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (cq_push && !cq_pop) begin
         count_d = count_q + 1'b1;
      end else if (!cq_push && cq_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // outputs decoded from registered state; head fields read 0 when empty
   always_comb begin
      job_ready  = (state_q == S_IDLE);
      busy       = (state_q != S_IDLE);
      wrap_reset = wrap_reset_q;
      wrap_start = wrap_start_q;
      cfg_lines  = lines_q;
      cpl_valid  = (count_q != '0);
      cpl_id     = '0;
      cpl_cycles = '0;
      cpl_status = '0;
      if (count_q != '0) begin
         cpl_id     = cq_id[rd_ptr_q];
         cpl_cycles = cq_cycles[rd_ptr_q];
         cpl_status = cq_status[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_gaussian_job_scheduler.sv
// tb/tb_gaussian_job_scheduler.sv - self-checking bench for gaussian_job_scheduler
module tb_gaussian_job_scheduler;

   localparam int LINE_W   = 18;
   localparam int CYCLE_W  = 32;
   localparam int TIMEOUT  = 16;
   localparam int CQ_DEPTH = 4;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               job_valid = 1'b0;
   logic               job_ready;
   logic [7:0]         job_id = '0;
   logic [LINE_W-1:0]  job_lines = '0;
   logic               abort = 1'b0;
   logic               wrap_reset;
   logic               wrap_start;
   logic               wrap_finish = 1'b0;
   logic [LINE_W-1:0]  cfg_lines;
   logic               busy;
   logic               cpl_valid;
   logic               cpl_ready = 1'b0;
   logic [7:0]         cpl_id;
   logic [CYCLE_W-1:0] cpl_cycles;
   logic [1:0]         cpl_status;

   gaussian_job_scheduler #(
      .LINE_W(LINE_W), .CYCLE_W(CYCLE_W), .TIMEOUT(TIMEOUT), .CQ_DEPTH(CQ_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
      .job_id(job_id), .job_lines(job_lines), .abort(abort),
      .wrap_reset(wrap_reset), .wrap_start(wrap_start), .wrap_finish(wrap_finish),
      .cfg_lines(cfg_lines), .busy(busy), .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
      .cpl_id(cpl_id), .cpl_cycles(cpl_cycles), .cpl_status(cpl_status)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]         id;
      logic [CYCLE_W-1:0] cyc;
      logic [1:0]         st;
   } rec_t;

   rec_t model_q[$];
   int   vecs = 0;
   int   errs = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Exit cycle (relative to accept at 0) from the rules: RUN starts at cycle 4,
   // cycles counted from START (cycle 3), finish > abort > timeout.
   task automatic predict(input logic [LINE_W-1:0] lines, input int fin_at, input int abort_at,
                          output int exit_c, output logic [1:0] st);
      exit_c = -1;
      st     = 2'b11;
      if (lines == '0) begin
         exit_c = 0;
      end else begin
         for (int c = 4; exit_c < 0; c++) begin
            if (fin_at >= 0 && c >= fin_at) begin
               exit_c = c; st = 2'b00;
            end else if (c == abort_at) begin
               exit_c = c; st = 2'b10;
            end else if (c - 2 == TIMEOUT) begin
               exit_c = c; st = 2'b01;
            end
         end
      end
   endtask

   // Runs one job with no pops and a non-full queue, checking every cycle.
   task automatic run_job(input logic [7:0] id, input logic [LINE_W-1:0] lines,
                          input int fin_at, input int abort_at);
      int exit_c;
      int post;
      int tn;
      logic [1:0] st;
      logic [CYCLE_W-1:0] cyc;
      logic exp_wr, exp_ws, exp_busy;
      predict(lines, fin_at, abort_at, exit_c, st);
      post = exit_c + 1;
      cyc  = (lines == '0) ? '0 : CYCLE_W'(exit_c - 2);
      vecs++;
      if (job_ready !== 1'b1) begin
         errs++; $display("FAIL job_ready_at_accept id=%0h: got %b, expected 1", id, job_ready);
      end
      job_valid = 1'b1; job_id = id; job_lines = lines;
      for (int t = 0; t <= post; t++) begin
         wrap_finish = (lines != '0) && fin_at >= 0 && t >= fin_at && t <= exit_c;
         abort = (t == abort_at);
         step();
         job_valid = 1'b0;
         tn = t + 1;
         if (tn == post + 1) model_q.push_back('{id, cyc, st});
         exp_wr   = ((lines != '0) && (tn == 1 || tn == 2)) ||
                    (tn == post && (st == 2'b01 || st == 2'b10));
         exp_ws   = (lines != '0) && (tn == 3);
         exp_busy = (tn <= post);
         vecs += 6;
         if (wrap_reset !== exp_wr) begin
            errs++; $display("FAIL wrap_reset id=%0h t=%0d: got %b, expected %b", id, tn, wrap_reset, exp_wr);
         end
         if (wrap_start !== exp_ws) begin
            errs++; $display("FAIL wrap_start id=%0h t=%0d: got %b, expected %b", id, tn, wrap_start, exp_ws);
         end
         if (busy !== exp_busy) begin
            errs++; $display("FAIL busy id=%0h t=%0d: got %b, expected %b", id, tn, busy, exp_busy);
         end
         if (job_ready !== !exp_busy) begin
            errs++; $display("FAIL job_ready id=%0h t=%0d: got %b, expected %b", id, tn, job_ready, !exp_busy);
         end
         if (cpl_valid !== (model_q.size() != 0)) begin
            errs++; $display("FAIL cpl_valid id=%0h t=%0d: got %b, expected %b", id, tn, cpl_valid, model_q.size() != 0);
         end
         if (cfg_lines !== lines) begin
            errs++; $display("FAIL cfg_lines id=%0h t=%0d: got %0d, expected %0d", id, tn, cfg_lines, lines);
         end
      end
      wrap_finish = 1'b0;
      abort = 1'b0;
   endtask

   // Pops n entries checking each head against the model, in order.
   task automatic drain(input int n);
      rec_t e;
      for (int i = 0; i < n; i++) begin
         if (model_q.size() == 0) break;
         e = model_q.pop_front();
         vecs += 4;
         if (cpl_valid !== 1'b1) begin
            errs++; $display("FAIL drain_valid: got %b, expected 1", cpl_valid);
         end
         if (cpl_id !== e.id) begin
            errs++; $display("FAIL cpl_id: got %0h, expected %0h", cpl_id, e.id);
         end
         if (cpl_cycles !== e.cyc) begin
            errs++; $display("FAIL cpl_cycles id=%0h: got %0d, expected %0d", e.id, cpl_cycles, e.cyc);
         end
         if (cpl_status !== e.st) begin
            errs++; $display("FAIL cpl_status id=%0h: got %b, expected %b", e.id, cpl_status, e.st);
         end
         cpl_ready = 1'b1;
         step();
         cpl_ready = 1'b0;
      end
      vecs++;
      if (cpl_valid !== (model_q.size() != 0)) begin
         errs++; $display("FAIL drain_after_valid: got %b, expected %b", cpl_valid, model_q.size() != 0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      vecs += 2;
      if (wrap_reset !== 1'b1) begin
         errs++; $display("FAIL reset_wrap_reset: got %b, expected 1", wrap_reset);
      end
      if (wrap_start !== 1'b0) begin
         errs++; $display("FAIL reset_wrap_start: got %b, expected 0", wrap_start);
      end
      step();
      reset = 1'b0;
      step();
      vecs += 6;
      if (job_ready !== 1'b1) begin
         errs++; $display("FAIL post_reset_job_ready: got %b, expected 1", job_ready);
      end
      if (wrap_reset !== 1'b0) begin
         errs++; $display("FAIL post_reset_wrap_reset: got %b, expected 0", wrap_reset);
      end
      if (busy !== 1'b0) begin
         errs++; $display("FAIL post_reset_busy: got %b, expected 0", busy);
      end
      if (cpl_valid !== 1'b0) begin
         errs++; $display("FAIL post_reset_cpl_valid: got %b, expected 0", cpl_valid);
      end
      if (cfg_lines !== '0) begin
         errs++; $display("FAIL post_reset_cfg_lines: got %0d, expected 0", cfg_lines);
      end
      if ({cpl_id, cpl_cycles, cpl_status} !== '0) begin
         errs++; $display("FAIL post_reset_cpl_fields: got %0h, expected 0", {cpl_id, cpl_cycles, cpl_status});
      end
   endtask

   task automatic test_normal();
      run_job(8'h05, 100, 10, -1);
      drain(1);
   endtask

   task automatic test_zero_length();
      run_job(8'h21, 0, -1, -1);
      drain(1);
   endtask

   task automatic test_watchdog();
      run_job(8'h31, 7, -1, -1);
      run_job(8'h32, 9, 18, -1);
      drain(2);
   endtask

   task automatic test_abort();
      run_job(8'h41, 12, -1, 6);
      run_job(8'h42, 12, 12, 1);
      run_job(8'h43, 12, 12, 3);
      drain(3);
   endtask

   task automatic test_back_to_back();
      run_job(8'h51, 3, 5, -1);
      run_job(8'h52, 0, -1, -1);
      run_job(8'h53, 4, 9, 9);
      drain(3);
   endtask

   task automatic test_queue_full();
      rec_t e;
      run_job(8'h10, 5, 7, -1);
      run_job(8'h11, 0, -1, -1);
      run_job(8'h12, 6, -1, 8);
      run_job(8'h13, 0, -1, -1);
      job_valid = 1'b1; job_id = 8'h14; job_lines = '0;
      step();
      job_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         vecs += 3;
         if (busy !== 1'b1 || job_ready !== 1'b0) begin
            errs++; $display("FAIL full_hold k=%0d: got busy=%b ready=%b, expected busy=1 ready=0", k, busy, job_ready);
         end
         if (cpl_valid !== 1'b1) begin
            errs++; $display("FAIL full_cpl_valid k=%0d: got %b, expected 1", k, cpl_valid);
         end
         if (wrap_reset !== 1'b0 || wrap_start !== 1'b0) begin
            errs++; $display("FAIL full_wrapper_idle k=%0d: got rst=%b start=%b, expected 0 0", k, wrap_reset, wrap_start);
         end
         step();
      end
      e = model_q.pop_front();
      vecs++;
      if (cpl_id !== e.id) begin
         errs++; $display("FAIL full_head_id: got %0h, expected %0h", cpl_id, e.id);
      end
      cpl_ready = 1'b1;
      step();
      cpl_ready = 1'b0;
      model_q.push_back('{8'h14, '0, 2'b11});
      vecs += 2;
      if (job_ready !== 1'b1 || busy !== 1'b0) begin
         errs++; $display("FAIL full_push_on_pop: got ready=%b busy=%b, expected ready=1 busy=0", job_ready, busy);
      end
      if (cpl_id !== 8'h11) begin
         errs++; $display("FAIL full_next_head: got %0h, expected 11", cpl_id);
      end
      drain(4);
   endtask

   task automatic test_pop_empty();
      cpl_ready = 1'b1;
      step();
      step();
      cpl_ready = 1'b0;
      vecs++;
      if (cpl_valid !== 1'b0) begin
         errs++; $display("FAIL pop_empty_valid: got %b, expected 0", cpl_valid);
      end
      run_job(8'h61, 2, 6, -1);
      drain(1);
   endtask

   task automatic test_reset_mid();
      run_job(8'h71, 0, -1, -1);
      run_job(8'h72, 0, -1, -1);
      job_valid = 1'b1; job_id = 8'h77; job_lines = 50;
      step();
      job_valid = 1'b0;
      for (int k = 0; k < 5; k++) step();
      vecs++;
      if (busy !== 1'b1) begin
         errs++; $display("FAIL mid_busy_before: got %b, expected 1", busy);
      end
      reset = 1'b1;
      step();
      model_q.delete();
      vecs += 4;
      if (busy !== 1'b0) begin
         errs++; $display("FAIL mid_reset_busy: got %b, expected 0", busy);
      end
      if (cpl_valid !== 1'b0) begin
         errs++; $display("FAIL mid_reset_cpl_valid: got %b, expected 0", cpl_valid);
      end
      if (cfg_lines !== '0) begin
         errs++; $display("FAIL mid_reset_cfg_lines: got %0d, expected 0", cfg_lines);
      end
      if (wrap_reset !== 1'b1 || wrap_start !== 1'b0) begin
         errs++; $display("FAIL mid_reset_wrap: got rst=%b start=%b, expected 1 0", wrap_reset, wrap_start);
      end
      reset = 1'b0;
      step();
      vecs++;
      if (job_ready !== 1'b1 || wrap_reset !== 1'b0) begin
         errs++; $display("FAIL mid_after_reset: got ready=%b rst=%b, expected 1 0", job_ready, wrap_reset);
      end
      run_job(8'h78, 33, 9, -1);
      drain(1);
   endtask

   task automatic test_random();
      int fin, ab;
      logic [LINE_W-1:0] ln;
      for (int j = 0; j < 30; j++) begin
         if (model_q.size() >= CQ_DEPTH || ($urandom_range(0, 2) == 0 && model_q.size() != 0))
            drain($urandom_range(1, model_q.size()));
         ln  = ($urandom_range(0, 4) == 0) ? '0 : LINE_W'($urandom_range(1, 1000));
         fin = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 24));
         ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 24)) : -1;
         run_job(8'(j + 8'h80), ln, fin, ab);
      end
      drain(model_q.size());
   endtask

   initial begin
      test_reset();
      test_normal();
      test_zero_length();
      test_watchdog();
      test_abort();
      test_back_to_back();
      test_queue_full();
      test_pop_empty();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
